// File: rtl/rs_ldst_age_pkg.sv
// Shared defaults for the age-ordered load/store reservation station.
package rs_ldst_age_pkg;

  localparam int RS_LDST_ENT_NUM = 4;   // entries in the station
  localparam int RS_LDST_ENT_SEL = 2;   // index width for RS_LDST_ENT_NUM entries
  localparam int RRF_ENT_SEL     = 6;   // rename register file tag width
  localparam int RV32_DATA_WIDTH = 32;  // operand / immediate width
  localparam int RS_LDST_CDB_NUM = 3;   // result broadcast channels

endpackage

// File: rtl/rs_ldst_age_ent.sv
// Single load/store reservation-station entry: busy flag, two operands with
// ready bits, CDB tag compare/capture, immediate, store flag and dest tag.
// Control state (busy, ready bits) is reset; payload registers are not, since
// they are only observed through a busy entry.
module rs_ldst_age_ent
  import rs_ldst_age_pkg::*;
#(
  parameter int DATA_W  = RV32_DATA_WIDTH,
  parameter int TAG_W   = RRF_ENT_SEL,
  parameter int CDB_NUM = RS_LDST_CDB_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic                      issue,
  input  logic                      wr_rs1_vld,
  input  logic [DATA_W-1:0]         wr_rs1,
  input  logic                      wr_rs2_vld,
  input  logic [DATA_W-1:0]         wr_rs2,
  input  logic [DATA_W-1:0]         wr_imm,
  input  logic                      wr_is_st,
  input  logic [TAG_W-1:0]          wr_rrftag,
  input  logic [CDB_NUM-1:0]        cdb_vld,
  input  logic [CDB_NUM*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_NUM*DATA_W-1:0] cdb_data,
  output logic                      busy,
  output logic                      rdy,
  output logic [DATA_W-1:0]         rs1,
  output logic [DATA_W-1:0]         rs2,
  output logic [DATA_W-1:0]         imm,
  output logic                      is_st,
  output logic [TAG_W-1:0]          rrftag
);

  logic rs1_rdy;
  logic rs2_rdy;

  // {hit, data} for a tag against all broadcast channels; lowest channel wins
  function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] res;
    res = '0;
    for (int c = CDB_NUM - 1; c >= 0; c--) begin
      if (cdb_vld[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, cdb_data[c*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  logic [DATA_W:0] wr1_lk;
  logic [DATA_W:0] wr2_lk;
  logic [DATA_W:0] cur1_lk;
  logic [DATA_W:0] cur2_lk;
  logic            wake1;
  logic            wake2;

  // Tag compares for the incoming dispatch operands and the held operands
  always_comb begin
    wr1_lk  = cdb_lookup(wr_rs1[TAG_W-1:0]);
    wr2_lk  = cdb_lookup(wr_rs2[TAG_W-1:0]);
    cur1_lk = cdb_lookup(rs1[TAG_W-1:0]);
    cur2_lk = cdb_lookup(rs2[TAG_W-1:0]);
    wake1   = busy && !rs1_rdy && cur1_lk[DATA_W];
    wake2   = busy && !rs2_rdy && cur2_lk[DATA_W];
  end

  assign rdy = busy & rs1_rdy & rs2_rdy;

  // Busy and operand-ready tracking; flush beats allocation and issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      rs1_rdy <= 1'b0;
      rs2_rdy <= 1'b0;
    end else if (flush) begin
      busy    <= 1'b0;
    end else if (alloc) begin
      busy    <= 1'b1;
      rs1_rdy <= wr_rs1_vld | wr1_lk[DATA_W];
      rs2_rdy <= wr_rs2_vld | wr2_lk[DATA_W];
    end else begin
      if (issue) busy    <= 1'b0;
      if (wake1) rs1_rdy <= 1'b1;
      if (wake2) rs2_rdy <= 1'b1;
    end
  end

  // Payload capture on allocation (with same-cycle CDB bypass) and on wakeup
  always_ff @(posedge clk) begin
    if (alloc) begin
      rs1    <= (!wr_rs1_vld && wr1_lk[DATA_W]) ? wr1_lk[DATA_W-1:0] : wr_rs1;
      rs2    <= (!wr_rs2_vld && wr2_lk[DATA_W]) ? wr2_lk[DATA_W-1:0] : wr_rs2;
      imm    <= wr_imm;
      is_st  <= wr_is_st;
      rrftag <= wr_rrftag;
    end else begin
      if (wake1) rs1 <= cur1_lk[DATA_W-1:0];
      if (wake2) rs2 <= cur2_lk[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/rs_ldst_age.sv
// Age-ordered load/store reservation station. Allocates up to two dispatch
// slots per cycle into free entries, wakes operands from the CDB and issues
// the oldest eligible entry over a valid/ready handshake.
// Optional build macro RS_LDST_STORE_ORDER_EN: an entry is held while any
// older busy store exists, so loads never pass stores and stores go in order.
module rs_ldst_age
  import rs_ldst_age_pkg::*;
#(
  parameter int ENT_NUM  = RS_LDST_ENT_NUM,
  parameter int DATA_W   = RV32_DATA_WIDTH,
  parameter int TAG_W    = RRF_ENT_SEL,
  parameter int CDB_NUM  = RS_LDST_CDB_NUM,
  localparam int CNT_W   = $clog2(ENT_NUM + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_stall,
  input  logic                      i_dp_vld_1,
  input  logic                      i_dp_rs1_vld_1,
  input  logic                      i_dp_rs2_vld_1,
  input  logic [DATA_W-1:0]         i_dp_rs1_1,
  input  logic [DATA_W-1:0]         i_dp_rs2_1,
  input  logic [DATA_W-1:0]         i_dp_imm_1,
  input  logic                      i_dp_is_st_1,
  input  logic [TAG_W-1:0]          i_dp_rrftag_1,
  input  logic                      i_dp_vld_2,
  input  logic                      i_dp_rs1_vld_2,
  input  logic                      i_dp_rs2_vld_2,
  input  logic [DATA_W-1:0]         i_dp_rs1_2,
  input  logic [DATA_W-1:0]         i_dp_rs2_2,
  input  logic [DATA_W-1:0]         i_dp_imm_2,
  input  logic                      i_dp_is_st_2,
  input  logic [TAG_W-1:0]          i_dp_rrftag_2,
  output logic                      o_dp_rdy,
  output logic [CNT_W-1:0]          o_free_cnt,
  output logic                      o_is_vld,
  input  logic                      i_is_rdy,
  output logic [DATA_W-1:0]         o_is_rs1,
  output logic [DATA_W-1:0]         o_is_rs2,
  output logic [DATA_W-1:0]         o_is_imm,
  output logic                      o_is_is_st,
  output logic [TAG_W-1:0]          o_is_rrftag,
  input  logic [CDB_NUM-1:0]        i_cdb_vld,
  input  logic [CDB_NUM*TAG_W-1:0]  i_cdb_tag,
  input  logic [CDB_NUM*DATA_W-1:0] i_cdb_data
);

  logic [ENT_NUM-1:0] busy;
  logic [ENT_NUM-1:0] rdy;
  logic [ENT_NUM-1:0] is_st;
  logic [ENT_NUM-1:0] elig;
  logic [ENT_NUM-1:0] sel;
  logic [ENT_NUM-1:0] first_free;
  logic [ENT_NUM-1:0] second_free;
  logic [ENT_NUM-1:0] alloc_s1;
  logic [ENT_NUM-1:0] alloc_s2;
  logic [ENT_NUM-1:0] alloc;
  logic [ENT_NUM-1:0] issue;
  logic [ENT_NUM-1:0] older [ENT_NUM];
  logic [DATA_W-1:0]  ent_rs1 [ENT_NUM];
  logic [DATA_W-1:0]  ent_rs2 [ENT_NUM];
  logic [DATA_W-1:0]  ent_imm [ENT_NUM];
  logic [TAG_W-1:0]   ent_tag [ENT_NUM];
  logic [CNT_W-1:0]   free_cnt;
  logic               got1;
  logic               got2;
  logic               accept;
  logic               acc1;
  logic               acc2;

  // Lowest and next-lowest free entries plus free count, from registered busy
  always_comb begin
    first_free  = '0;
    second_free = '0;
    got1        = 1'b0;
    got2        = 1'b0;
    free_cnt    = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!busy[i]) begin
        free_cnt = free_cnt + CNT_W'(1);
        if (!got1) begin
          first_free[i] = 1'b1;
          got1          = 1'b1;
        end else if (!got2) begin
          second_free[i] = 1'b1;
          got2           = 1'b1;
        end
      end
    end
  end

  assign o_free_cnt = free_cnt;
  assign o_dp_rdy   = (free_cnt >= CNT_W'(2));
  assign accept     = o_dp_rdy & ~i_stall & ~i_flush;
  assign acc1       = i_dp_vld_1 & accept;
  assign acc2       = i_dp_vld_2 & accept;
  assign alloc_s1   = acc1 ? first_free : '0;
  assign alloc_s2   = acc2 ? (acc1 ? second_free : first_free) : '0;
  assign alloc      = alloc_s1 | alloc_s2;
  assign issue      = sel & {ENT_NUM{i_is_rdy}};

  for (genvar g = 0; g < ENT_NUM; g++) begin : g_ent
    rs_ldst_age_ent #(
      .DATA_W  (DATA_W),
      .TAG_W   (TAG_W),
      .CDB_NUM (CDB_NUM)
    ) u_ent (
      .clk        (clk),
      .rst        (rst),
      .flush      (i_flush),
      .alloc      (alloc[g]),
      .issue      (issue[g]),
      .wr_rs1_vld (alloc_s1[g] ? i_dp_rs1_vld_1 : i_dp_rs1_vld_2),
      .wr_rs1     (alloc_s1[g] ? i_dp_rs1_1     : i_dp_rs1_2),
      .wr_rs2_vld (alloc_s1[g] ? i_dp_rs2_vld_1 : i_dp_rs2_vld_2),
      .wr_rs2     (alloc_s1[g] ? i_dp_rs2_1     : i_dp_rs2_2),
      .wr_imm     (alloc_s1[g] ? i_dp_imm_1     : i_dp_imm_2),
      .wr_is_st   (alloc_s1[g] ? i_dp_is_st_1   : i_dp_is_st_2),
      .wr_rrftag  (alloc_s1[g] ? i_dp_rrftag_1  : i_dp_rrftag_2),
      .cdb_vld    (i_cdb_vld),
      .cdb_tag    (i_cdb_tag),
      .cdb_data   (i_cdb_data),
      .busy       (busy[g]),
      .rdy        (rdy[g]),
      .rs1        (ent_rs1[g]),
      .rs2        (ent_rs2[g]),
      .imm        (ent_imm[g]),
      .is_st      (is_st[g]),
      .rrftag     (ent_tag[g])
    );
  end

  // Age matrix: a new entry is younger than every busy entry; slot 1 beats slot 2.
  // Rows of idle entries may hold stale bits; they are rewritten on allocation
  // and never consulted because only busy/ready entries are compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENT_NUM; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < ENT_NUM; i++) begin
        for (int j = 0; j < ENT_NUM; j++) begin
          if (i != j) begin
            if (alloc[i])      older[i][j] <= alloc_s1[i] & alloc_s2[j];
            else if (alloc[j]) older[i][j] <= busy[i];
          end
        end
      end
    end
  end

  // Issue eligibility, optionally holding anything behind an older store
  always_comb begin
    elig = rdy;
`ifdef RS_LDST_STORE_ORDER_EN
    for (int i = 0; i < ENT_NUM; i++) begin
      for (int j = 0; j < ENT_NUM; j++) begin
        if ((j != i) && busy[j] && is_st[j] && older[j][i]) elig[i] = 1'b0;
      end
    end
`endif
  end

  // Oldest-eligible select: an eligible entry with no older eligible entry
  always_comb begin
    sel = elig;
    for (int i = 0; i < ENT_NUM; i++) begin
      for (int j = 0; j < ENT_NUM; j++) begin
        if ((j != i) && elig[j] && older[j][i]) sel[i] = 1'b0;
      end
    end
  end

  // One-hot output mux; all-zero when nothing is selected
  always_comb begin
    o_is_vld    = |elig;
    o_is_rs1    = '0;
    o_is_rs2    = '0;
    o_is_imm    = '0;
    o_is_is_st  = 1'b0;
    o_is_rrftag = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      o_is_rs1    = o_is_rs1    | ({DATA_W{sel[i]}} & ent_rs1[i]);
      o_is_rs2    = o_is_rs2    | ({DATA_W{sel[i]}} & ent_rs2[i]);
      o_is_imm    = o_is_imm    | ({DATA_W{sel[i]}} & ent_imm[i]);
      o_is_is_st  = o_is_is_st  | (sel[i] & is_st[i]);
      o_is_rrftag = o_is_rrftag | ({TAG_W{sel[i]}} & ent_tag[i]);
    end
  end

endmodule

// File: tb/tb_rs_ldst_age.sv
// Scoreboard bench for rs_ldst_age: stimulus pushes expected issue records,
// a negedge monitor pops and compares on every accepted issue.
module tb_rs_ldst_age;

  localparam int DW = 32;
  localparam int TW = 6;
  localparam int CN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_flush, i_stall;
  logic          i_dp_vld_1, i_dp_rs1_vld_1, i_dp_rs2_vld_1, i_dp_is_st_1;
  logic [DW-1:0] i_dp_rs1_1, i_dp_rs2_1, i_dp_imm_1;
  logic [TW-1:0] i_dp_rrftag_1;
  logic          i_dp_vld_2, i_dp_rs1_vld_2, i_dp_rs2_vld_2, i_dp_is_st_2;
  logic [DW-1:0] i_dp_rs1_2, i_dp_rs2_2, i_dp_imm_2;
  logic [TW-1:0] i_dp_rrftag_2;
  logic          o_dp_rdy;
  logic [2:0]    o_free_cnt;
  logic          o_is_vld, i_is_rdy;
  logic [DW-1:0] o_is_rs1, o_is_rs2, o_is_imm;
  logic          o_is_is_st;
  logic [TW-1:0] o_is_rrftag;
  logic [CN-1:0]    i_cdb_vld;
  logic [CN*TW-1:0] i_cdb_tag;
  logic [CN*DW-1:0] i_cdb_data;

  rs_ldst_age dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_stall(i_stall),
    .i_dp_vld_1(i_dp_vld_1), .i_dp_rs1_vld_1(i_dp_rs1_vld_1), .i_dp_rs2_vld_1(i_dp_rs2_vld_1),
    .i_dp_rs1_1(i_dp_rs1_1), .i_dp_rs2_1(i_dp_rs2_1), .i_dp_imm_1(i_dp_imm_1),
    .i_dp_is_st_1(i_dp_is_st_1), .i_dp_rrftag_1(i_dp_rrftag_1),
    .i_dp_vld_2(i_dp_vld_2), .i_dp_rs1_vld_2(i_dp_rs1_vld_2), .i_dp_rs2_vld_2(i_dp_rs2_vld_2),
    .i_dp_rs1_2(i_dp_rs1_2), .i_dp_rs2_2(i_dp_rs2_2), .i_dp_imm_2(i_dp_imm_2),
    .i_dp_is_st_2(i_dp_is_st_2), .i_dp_rrftag_2(i_dp_rrftag_2),
    .o_dp_rdy(o_dp_rdy), .o_free_cnt(o_free_cnt), .o_is_vld(o_is_vld), .i_is_rdy(i_is_rdy),
    .o_is_rs1(o_is_rs1), .o_is_rs2(o_is_rs2), .o_is_imm(o_is_imm),
    .o_is_is_st(o_is_is_st), .o_is_rrftag(o_is_rrftag),
    .i_cdb_vld(i_cdb_vld), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [DW-1:0] imm;
    logic          is_st;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                              input logic [DW-1:0] imm, input logic st, input logic [TW-1:0] tag);
    exp_t e;
    e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.is_st = st; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic dp1(input logic r1v, input logic [DW-1:0] r1, input logic r2v, input logic [DW-1:0] r2,
                     input logic [DW-1:0] imm, input logic st, input logic [TW-1:0] tag);
    i_dp_vld_1 = 1'b1; i_dp_rs1_vld_1 = r1v; i_dp_rs1_1 = r1; i_dp_rs2_vld_1 = r2v;
    i_dp_rs2_1 = r2; i_dp_imm_1 = imm; i_dp_is_st_1 = st; i_dp_rrftag_1 = tag;
  endtask

  task automatic dp2(input logic r1v, input logic [DW-1:0] r1, input logic r2v, input logic [DW-1:0] r2,
                     input logic [DW-1:0] imm, input logic st, input logic [TW-1:0] tag);
    i_dp_vld_2 = 1'b1; i_dp_rs1_vld_2 = r1v; i_dp_rs1_2 = r1; i_dp_rs2_vld_2 = r2v;
    i_dp_rs2_2 = r2; i_dp_imm_2 = imm; i_dp_is_st_2 = st; i_dp_rrftag_2 = tag;
  endtask

  task automatic clr_dp;
    i_dp_vld_1 = 0; i_dp_rs1_vld_1 = 0; i_dp_rs2_vld_1 = 0; i_dp_is_st_1 = 0;
    i_dp_rs1_1 = '0; i_dp_rs2_1 = '0; i_dp_imm_1 = '0; i_dp_rrftag_1 = '0;
    i_dp_vld_2 = 0; i_dp_rs1_vld_2 = 0; i_dp_rs2_vld_2 = 0; i_dp_is_st_2 = 0;
    i_dp_rs1_2 = '0; i_dp_rs2_2 = '0; i_dp_imm_2 = '0; i_dp_rrftag_2 = '0;
  endtask

  task automatic cdb(input int ch, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    i_cdb_vld[ch] = 1'b1;
    i_cdb_tag[ch*TW +: TW] = tag;
    i_cdb_data[ch*DW +: DW] = data;
  endtask

  task automatic clr_cdb;
    i_cdb_vld = '0; i_cdb_tag = '0; i_cdb_data = '0;
  endtask

  // Monitor: every accepted issue must match the head of the scoreboard
  initial begin
    exp_t got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_is_vld && i_is_rdy) begin
        got = {o_is_rs1, o_is_rs2, o_is_imm, o_is_is_st, o_is_rrftag};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: got tag=%0d rs1=0x%0h, expected no issue", got.tag, got.rs1);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL issue_tag%0d: got rs1=0x%0h rs2=0x%0h imm=0x%0h st=%0b tag=%0d, expected rs1=0x%0h rs2=0x%0h imm=0x%0h st=%0b tag=%0d",
                     e.tag, got.rs1, got.rs2, got.imm, got.is_st, got.tag, e.rs1, e.rs2, e.imm, e.is_st, e.tag);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; i_flush = 0; i_stall = 0; i_is_rdy = 0;
    clr_dp; clr_cdb;
    #12;
    chk("rst_vld", o_is_vld, 0);
    chk("rst_free", o_free_cnt, 4);
    chk("rst_dp_rdy", o_dp_rdy, 1);
    chk("rst_rs1", o_is_rs1, 0);
    rst = 1'b0;

    // two ready loads, back-to-back issue in age order
    i_is_rdy = 1;
    expect_issue(32'h11, 32'h22, 32'h33, 0, 5);
    expect_issue(32'h44, 32'h55, 32'h66, 0, 6);
    dp1(1, 32'h11, 1, 32'h22, 32'h33, 0, 5);
    dp2(1, 32'h44, 1, 32'h55, 32'h66, 0, 6);
    step; clr_dp;
    chk("t1_vld", o_is_vld, 1);
    chk("t1_first_tag", o_is_rrftag, 5);
    chk("t1_free2", o_free_cnt, 2);
    step;
    chk("t1_second_tag", o_is_rrftag, 6);
    chk("t1_free3", o_free_cnt, 3);
    step;
    chk("t1_empty_vld", o_is_vld, 0);
    chk("t1_free4", o_free_cnt, 4);

    // wakeup from CDB channel 2
    dp1(0, 32'd9, 1, 32'h2, 32'h4, 0, 10);
    step; clr_dp;
    chk("t2_wait_vld", o_is_vld, 0);
    chk("t2_free3", o_free_cnt, 3);
    cdb(2, 9, 32'h1000);
    expect_issue(32'h1000, 32'h2, 32'h4, 0, 10);
    step; clr_cdb;
    chk("t2_woke_vld", o_is_vld, 1);
    chk("t2_rs1", o_is_rs1, 32'h1000);
    step;
    chk("t2_free4", o_free_cnt, 4);

    // dispatch-cycle CDB bypass
    dp1(0, 32'd3, 1, 32'h5, 32'h7, 0, 11);
    cdb(0, 3, 32'hAB);
    expect_issue(32'hAB, 32'h5, 32'h7, 0, 11);
    step; clr_dp; clr_cdb;
    chk("t3_vld", o_is_vld, 1);
    chk("t3_rs1", o_is_rs1, 32'hAB);
    step;
    chk("t3_empty", o_is_vld, 0);

    // fill, drop extra dispatch, youngest wakes first, channel priority
    dp1(0, 32'd20, 1, 32'h120, 32'h0, 0, 30);
    dp2(0, 32'd21, 1, 32'h121, 32'h0, 0, 31);
    step;
    dp1(0, 32'd22, 1, 32'h122, 32'h0, 0, 32);
    dp2(0, 32'd23, 1, 32'h123, 32'h0, 0, 33);
    step; clr_dp;
    chk("t4_full_free", o_free_cnt, 0);
    chk("t4_full_dp_rdy", o_dp_rdy, 0);
    chk("t4_full_vld", o_is_vld, 0);
    dp1(1, 32'h99, 1, 32'h99, 32'h0, 0, 40);
    step; clr_dp;
    chk("t4_drop_free", o_free_cnt, 0);
    chk("t4_drop_vld", o_is_vld, 0);
    cdb(1, 23, 32'h77);
    cdb(2, 23, 32'h88);
    expect_issue(32'h77, 32'h123, 32'h0, 0, 33);
    step; clr_cdb;
    chk("t4_young_vld", o_is_vld, 1);
    chk("t4_young_tag", o_is_rrftag, 33);
    chk("t4_young_rs1", o_is_rs1, 32'h77);
    cdb(0, 20, 32'hA0);
    cdb(1, 21, 32'hA1);
    cdb(2, 22, 32'hA2);
    expect_issue(32'hA0, 32'h120, 32'h0, 0, 30);
    expect_issue(32'hA1, 32'h121, 32'h0, 0, 31);
    expect_issue(32'hA2, 32'h122, 32'h0, 0, 32);
    step; clr_cdb;
    chk("t4_free1", o_free_cnt, 1);
    chk("t4_tag30", o_is_rrftag, 30);
    step;
    chk("t4_tag31", o_is_rrftag, 31);
    step;
    chk("t4_tag32", o_is_rrftag, 32);
    step;
    chk("t4_free4", o_free_cnt, 4);
    chk("t4_empty", o_is_vld, 0);

    // older waiting store, younger ready load
    dp1(1, 32'h100, 0, 32'd25, 32'h8, 1, 41);
    dp2(1, 32'h200, 1, 32'h201, 32'h9, 0, 42);
`ifdef RS_LDST_STORE_ORDER_EN
    expect_issue(32'h100, 32'h55, 32'h8, 1, 41);
    expect_issue(32'h200, 32'h201, 32'h9, 0, 42);
    step; clr_dp;
    chk("t5_load_held", o_is_vld, 0);
    step;
    chk("t5_load_held2", o_is_vld, 0);
    cdb(0, 25, 32'h55);
    step; clr_cdb;
    chk("t5_store_tag", o_is_rrftag, 41);
    step;
    chk("t5_load_tag", o_is_rrftag, 42);
    step;
    chk("t5_free4", o_free_cnt, 4);
`else
    expect_issue(32'h200, 32'h201, 32'h9, 0, 42);
    expect_issue(32'h100, 32'h55, 32'h8, 1, 41);
    step; clr_dp;
    chk("t5_load_vld", o_is_vld, 1);
    chk("t5_load_tag", o_is_rrftag, 42);
    step;
    chk("t5_store_wait", o_is_vld, 0);
    cdb(0, 25, 32'h55);
    step; clr_cdb;
    chk("t5_store_tag", o_is_rrftag, 41);
    chk("t5_store_flag", o_is_is_st, 1);
    step;
    chk("t5_free4", o_free_cnt, 4);
`endif

    // hold, flush, then async reset mid-dispatch
    i_is_rdy = 0;
    dp1(1, 32'h1, 1, 32'h2, 32'h3, 0, 50);
    step; clr_dp;
    chk("t6_vld", o_is_vld, 1);
    chk("t6_tag", o_is_rrftag, 50);
    step;
    chk("t6_hold_tag", o_is_rrftag, 50);
    i_flush = 1;
    step;
    i_flush = 0;
    chk("t6_flush_vld", o_is_vld, 0);
    chk("t6_flush_free", o_free_cnt, 4);
    chk("t6_flush_rs1", o_is_rs1, 0);
    dp1(1, 32'h61, 1, 32'h62, 32'h63, 1, 51);
    step;
    chk("t6_pre_rst_tag", o_is_rrftag, 51);
    chk("t6_pre_rst_free", o_free_cnt, 3);
    dp1(1, 32'h71, 1, 32'h72, 32'h73, 0, 52);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_vld", o_is_vld, 0);
    chk("t6_arst_free", o_free_cnt, 4);
    chk("t6_arst_dp_rdy", o_dp_rdy, 1);
    chk("t6_arst_tag", o_is_rrftag, 0);
    chk("t6_arst_rs1", o_is_rs1, 0);
    clr_dp;
    #2 rst = 1'b0;
    step;
    chk("t6_post_vld", o_is_vld, 0);
    chk("t6_post_free", o_free_cnt, 4);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
